td4_register_bank: RTL and testbench

//   Architectural state of the 4-bit CPU, directly downstream of the ripple adder.

---
 rtl/td4_pkg.sv | 15 +
 rtl/td4_program_counter.sv | 26 ++
 rtl/td4_register_bank.sv | 75 +++++++
 tb/tb_td4_register_bank.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: load-select bit positions, default widths and the
// load-select type used by both the decoder and the register bank.
package td4_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int PC_WIDTH_DEF = 4;

    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;

    typedef logic [3:0] load_sel_t;

endpackage

// File: rtl/td4_program_counter.sv
// TD4 program counter: a jump load wins over increment; increment wraps
// modulo 2**PC_WIDTH.
module td4_program_counter #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            if (load) begin
                pc <= load_value;
            end else begin
                pc <= pc + PC_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/td4_register_bank.sv
// TD4 architectural state: A, B, OUT, PC and the carry flag, loaded from the
// ripple adder. The optional zero flag is built when ZERO_FLAG_EN is defined.
module td4_register_bank
    import td4_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [WIDTH-1:0]    i_sum,
    input  logic                i_carry,
    input  logic [3:0]          i_load,
    output logic [WIDTH-1:0]    o_reg_a,
    output logic [WIDTH-1:0]    o_reg_b,
    output logic [WIDTH-1:0]    o_out,
    output logic [PC_WIDTH-1:0] o_pc,
`ifdef ZERO_FLAG_EN
    output logic                o_zero_flag,
`endif
    output logic                o_carry_flag
);

    load_sel_t             load_sel;
    logic [PC_WIDTH-1:0]   pc_load_value;

    assign load_sel = i_load;

    // Jump target: the sum is zero-extended or truncated to the PC width.
    generate
        if (PC_WIDTH > WIDTH) begin : g_pc_ext
            assign pc_load_value = {{(PC_WIDTH-WIDTH){1'b0}}, i_sum};
        end else begin : g_pc_trunc
            assign pc_load_value = i_sum[PC_WIDTH-1:0];
        end
    endgenerate

    td4_program_counter #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc (
        .clk        (i_clk),
        .rst        (i_rst),
        .en         (i_en),
        .load       (load_sel[LD_PC]),
        .load_value (pc_load_value),
        .pc         (o_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_reg_a      <= '0;
            o_reg_b      <= '0;
            o_out        <= '0;
            o_carry_flag <= 1'b0;
        end else if (i_en) begin
            if (load_sel[LD_A])   o_reg_a <= i_sum;
            if (load_sel[LD_B])   o_reg_b <= i_sum;
            if (load_sel[LD_OUT]) o_out   <= i_sum;
            // Carry tracks every enabled step, including NOPs.
            o_carry_flag <= i_carry;
        end
    end

`ifdef ZERO_FLAG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_zero_flag <= 1'b0;
        end else if (i_en) begin
            o_zero_flag <= (i_sum == '0);
        end
    end
`endif

endmodule

// File: tb/tb_td4_register_bank.sv
// Directed bench for td4_register_bank; checks the zero flag when ZERO_FLAG_EN
// is defined.
module tb_td4_register_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] sum;
    logic       carry;
    logic [3:0] load;
    logic [3:0] reg_a, reg_b, out_q, pc;
    logic       carry_flag;
`ifdef ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    td4_register_bank #(.WIDTH(4), .PC_WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_sum        (sum),
        .i_carry      (carry),
        .i_load       (load),
        .o_reg_a      (reg_a),
        .o_reg_b      (reg_b),
        .o_out        (out_q),
        .o_pc         (pc),
`ifdef ZERO_FLAG_EN
        .o_zero_flag  (zero_flag),
`endif
        .o_carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] ld,
                        input logic [3:0] s, input logic c);
        rst = r; en = e; load = ld; sum = s; carry = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] eo, input logic [3:0] ep, input logic ec);
        chk({tag, ".a"},   32'(reg_a),      32'(ea));
        chk({tag, ".b"},   32'(reg_b),      32'(eb));
        chk({tag, ".out"}, 32'(out_q),      32'(eo));
        chk({tag, ".pc"},  32'(pc),         32'(ep));
        chk({tag, ".c"},   32'(carry_flag), 32'(ec));
    endtask

    task automatic chk_zero(input string tag, input logic ez);
`ifdef ZERO_FLAG_EN
        chk({tag, ".z"}, 32'(zero_flag), 32'(ez));
`else
        if (ez === 1'bx) $display("zero flag not built (%s)", tag);
`endif
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 4'h0; sum = 4'h0; carry = 1'b0;
        #2;

        // Garbage state, then reset while en=1 and load=F.
        step(1'b0, 1'b1, 4'hF, 4'hA, 1'b1);
        step(1'b0, 1'b1, 4'hF, 4'h6, 1'b1);
        chk_all("garbage", 4'h6, 4'h6, 4'h6, 4'h6, 1'b1);
        step(1'b1, 1'b1, 4'hF, 4'h9, 1'b1);
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk_zero("reset", 1'b0);

        // Load A only.
        step(1'b0, 1'b1, 4'b0001, 4'h9, 1'b1);
        chk_all("load_a", 4'h9, 4'h0, 4'h0, 4'h1, 1'b1);
        chk_zero("load_a", 1'b0);

        // 16 NOPs from PC=0 with alternating carry: PC walks 1..15 then wraps to 0.
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_all("reset2", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h0, 4'h5, i[0]);
            chk("wrap.pc", 32'(pc), 32'((i + 1) % 16));
            chk("wrap.c",  32'(carry_flag), 32'(i[0]));
        end

        // Jump to 5, then to 2 (not 6), then a multi-load to C.
        step(1'b0, 1'b1, 4'b1000, 4'h5, 1'b0);
        chk("jump5.pc", 32'(pc), 32'h5);
        step(1'b0, 1'b1, 4'b1000, 4'h2, 1'b0);
        chk_all("jump2", 4'h0, 4'h0, 4'h0, 4'h2, 1'b0);
        step(1'b0, 1'b1, 4'b1011, 4'hC, 1'b0);
        chk_all("multi", 4'hC, 4'hC, 4'h0, 4'hC, 1'b0);
        chk_zero("multi", 1'b0);

        // Zero flag on a zero sum, cleared on a nonzero sum.
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
        chk_all("zero1", 4'hC, 4'hC, 4'h0, 4'hD, 1'b1);
        chk_zero("zero1", 1'b1);
        step(1'b0, 1'b1, 4'h0, 4'h3, 1'b0);
        chk_all("zero0", 4'hC, 4'hC, 4'h0, 4'hE, 1'b0);
        chk_zero("zero0", 1'b0);

        // Load OUT, then hold for 3 cycles while inputs toggle (including X).
        step(1'b0, 1'b1, 4'b0100, 4'h7, 1'b1);
        chk_all("load_out", 4'hC, 4'hC, 4'h7, 4'hF, 1'b1);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
        chk_all("hold1", 4'hC, 4'hC, 4'h7, 4'hF, 1'b1);
        chk_zero("hold1", 1'b0);
        step(1'b0, 1'b0, 4'b1011, 4'h5, 1'b0);
        chk_all("hold2", 4'hC, 4'hC, 4'h7, 4'hF, 1'b1);
        step(1'b0, 1'b0, 4'hx, 4'hx, 1'bx);
        chk_all("hold3", 4'hC, 4'hC, 4'h7, 4'hF, 1'b1);
        chk_zero("hold3", 1'b0);

        // Re-enable: PC increments and wraps F -> 0.
        step(1'b0, 1'b1, 4'h0, 4'h1, 1'b0);
        chk_all("resume", 4'hC, 4'hC, 4'h7, 4'h0, 1'b0);
        chk_zero("resume", 1'b0);

        // Reset mid-program wins over a pending jump.
        step(1'b1, 1'b1, 4'b1111, 4'h9, 1'b1);
        chk_all("reset3", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("after_rst.pc", 32'(pc), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
